dense_activation_stage: RTL

Post-processing stage directly downstream of the dense layer. It captures the layer's NEURON_NB signed 4·WIDTH-bit accumulator outputs when the layer signals done. It rescales each value with a rounding arithmetic right shift, optionally applies ReLU, and saturates the result to 2·WIDTH bits. The output vector has the same shape and width as a dense layer's `in_data`, so it can feed the next dense layer directly.

---
 rtl/dense_activation_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dense_activation_stage.sv
// ---------------------------------------------------------------------------
// dense_activation_stage
//
// Post-processing stage that sits behind a dense layer. A rising edge on
// in_done captures the layer's accumulators one element per cycle. Each
// element is rescaled with a rounding arithmetic right shift (round half
// toward +inf), optionally clamped by ReLU, and saturated to 2*WIDTH bits.
// The act_out vector has the same shape as a dense layer's input vector.
//
// Build option:
//   DENSE_ACT_RELU_EN  defined   -> negative results are forced to 0
//                      undefined -> signed results saturate at both bounds
//
// Parameters:
//   NEURON_NB  vector length (>= 1)
//   WIDTH      base width; inputs are 4*WIDTH bits, outputs are 2*WIDTH bits
//   SHIFT      right-shift amount, 0 <= SHIFT < 4*WIDTH
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_done    sticky done level from the upstream layer; rising edge starts a run
//   acc_in     upstream accumulators; held stable while busy
//   act_out    registered activations
//   act_valid  high while act_out holds a complete result
//   busy       high while a run is in progress
// ---------------------------------------------------------------------------
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | after reset, no result held
//  RUN   | writing act_out[idx], one element per cycle
//  DONE  | complete result held, act_valid high, waiting for next start
// ---------------------------------------------------------------------------
module dense_activation_stage #(
    parameter int NEURON_NB = 32,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_done,
    input  logic signed [4*WIDTH-1:0]     acc_in  [0:NEURON_NB-1],
    output logic signed [2*WIDTH-1:0]     act_out [0:NEURON_NB-1],
    output logic                          act_valid,
    output logic                          busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_NB - 1);

    // One guard bit above the input so the rounding add cannot wrap.
    localparam int AW = 4*WIDTH + 1;

    // Half an LSB of the shifted result; evaluates to 0 when SHIFT is 0,
    // which makes the shift path a plain pass-through.
    localparam logic [AW-1:0] ROUND = (AW'(1) << SHIFT) >> 1;

    localparam logic signed [AW-1:0] SAT_MAX = $signed((AW'(1) << (2*WIDTH-1)) - AW'(1));
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]                state;
    logic [IDX_W-1:0]          idx;
    logic                      in_done_q;
    logic                      start;

    logic signed [4*WIDTH-1:0] acc_sel;
    logic signed [AW-1:0]      acc_ext;
    logic signed [AW-1:0]      rounded;
    logic signed [AW-1:0]      shifted;
    logic signed [2*WIDTH-1:0] act_next;

    assign start = in_done & ~in_done_q;

    // Single shared datapath; the FSM walks idx across the vector.
    always_comb begin
        acc_sel  = acc_in[idx];
        acc_ext  = {acc_sel[4*WIDTH-1], acc_sel};
        rounded  = acc_ext + $signed(ROUND);
        shifted  = rounded >>> SHIFT;
`ifdef DENSE_ACT_RELU_EN
        if (shifted < 0) begin
            shifted = '0;
        end
`endif
        act_next = shifted[2*WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            act_next = SAT_MAX[2*WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            act_next = SAT_MIN[2*WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            in_done_q <= 1'b0;
            act_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NEURON_NB; i++) begin
                act_out[i] <= '0;
            end
        end else begin
            in_done_q <= in_done;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        busy      <= 1'b1;
                        act_valid <= 1'b0;
                    end
                end
                RUN: begin
                    // Starts seen here are deliberately dropped: acc_in is
                    // only guaranteed stable for the run already in flight.
                    act_out[idx] <= act_next;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        idx       <= '0;
                        act_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
